// File: rtl/matrix_mult_host_driver.sv
// matrix_mult_host_driver
//   Host-side driver for a matrix multiplier's load/read interface.
//   A valid/ready stream of 2*N*N words (A row-major, then B row-major)
//   becomes indexed single-cycle write strobes on the a_*/b_* ports. Once
//   the multiplier raises z_stb, the result array is walked row-major
//   through z_i/z_j. Each element is returned on a valid/ready output
//   stream, and m_last marks element (N-1,N-1).
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  input word stream
//   a_in/a_i/a_j/a_we  A write port to the multiplier (registered)
//   b_in/b_i/b_j/b_we  B write port to the multiplier (registered)
//   z_stb              multiplier result-ready level
//   z_i/z_j/z_out      result read index (out) and read data (in)
//   m_valid/m_ready/m_data/m_last  result word stream
//   busy               high whenever the driver is not idle
module matrix_mult_host_driver #(
  parameter int N      = 4,
  parameter int IW     = $clog2(N),
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  output logic [31:0]   a_in,
  output logic [IW-1:0] a_i,
  output logic [IW-1:0] a_j,
  output logic          a_we,
  output logic [31:0]   b_in,
  output logic [IW-1:0] b_i,
  output logic [IW-1:0] b_j,
  output logic          b_we,
  input  logic          z_stb,
  output logic [IW-1:0] z_i,
  output logic [IW-1:0] z_j,
  input  logic [31:0]   z_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WAIT_STB,
    RD_WAIT,
    RD_HOLD
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [2:0]    LAT      = 3'(RD_LAT);

  state_e        state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [2:0]    lat_q, lat_d;
  logic [31:0]   a_in_q, a_in_d;
  logic [IW-1:0] a_i_q, a_i_d, a_j_q, a_j_d;
  logic          a_we_q, a_we_d;
  logic [31:0]   b_in_q, b_in_d;
  logic [IW-1:0] b_i_q, b_i_d, b_j_q, b_j_d;
  logic          b_we_q, b_we_d;
  logic [IW-1:0] z_i_q, z_i_d, z_j_q, z_j_d;
  logic          m_valid_q, m_valid_d;
  logic [31:0]   m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          accept;
  logic          load_end;
  logic          z_end;

  assign s_ready  = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy     = (state_q != IDLE);
  assign accept   = s_valid && s_ready;
  assign load_end = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign z_end    = (z_i_q == LAST_IDX) && (z_j_q == LAST_IDX);

  // Next-state and registered-output logic. Write enables default low so
  // every accepted word produces exactly one single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    lat_d     = lat_q;
    a_in_d    = a_in_q;
    a_i_d     = a_i_q;
    a_j_d     = a_j_q;
    a_we_d    = 1'b0;
    b_in_d    = b_in_q;
    b_i_d     = b_i_q;
    b_j_d     = b_j_q;
    b_we_d    = 1'b0;
    z_i_d     = z_i_q;
    z_j_d     = z_j_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;

    case (state_q)
      IDLE: begin
        // The first word of a load is always A[0][0].
        if (accept) begin
          a_we_d  = 1'b1;
          a_in_d  = s_data;
          a_i_d   = '0;
          a_j_d   = '0;
          row_d   = '0;
          col_d   = ONE_IDX;
          state_d = LOAD_A;
        end
      end

      LOAD_A: begin
        if (accept) begin
          a_we_d = 1'b1;
          a_in_d = s_data;
          a_i_d  = row_q;
          a_j_d  = col_q;
          if (load_end) begin
            row_d   = '0;
            col_d   = '0;
            state_d = LOAD_B;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + ONE_IDX;
          end else begin
            col_d = col_q + ONE_IDX;
          end
        end
      end

      LOAD_B: begin
        if (accept) begin
          b_we_d = 1'b1;
          b_in_d = s_data;
          b_i_d  = row_q;
          b_j_d  = col_q;
          if (load_end) begin
            row_d   = '0;
            col_d   = '0;
            state_d = WAIT_STB;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + ONE_IDX;
          end else begin
            col_d = col_q + ONE_IDX;
          end
        end
      end

      WAIT_STB: begin
        z_i_d = '0;
        z_j_d = '0;
        if (z_stb) begin
          lat_d   = '0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        // lat_q counts cycles since z_i/z_j last changed; z_out is trusted
        // once it reaches the read latency (immediately when RD_LAT is 0).
        if (lat_q == LAT) begin
          m_data_d  = z_out;
          m_valid_d = 1'b1;
          m_last_d  = z_end;
          state_d   = RD_HOLD;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      RD_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          lat_d     = '0;
          if (m_last_q) begin
            z_i_d   = '0;
            z_j_d   = '0;
            state_d = IDLE;
          end else begin
            if (z_j_q == LAST_IDX) begin
              z_j_d = '0;
              z_i_d = z_i_q + ONE_IDX;
            end else begin
              z_j_d = z_j_q + ONE_IDX;
            end
            state_d = RD_WAIT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any load or readout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      lat_q     <= '0;
      a_in_q    <= '0;
      a_i_q     <= '0;
      a_j_q     <= '0;
      a_we_q    <= 1'b0;
      b_in_q    <= '0;
      b_i_q     <= '0;
      b_j_q     <= '0;
      b_we_q    <= 1'b0;
      z_i_q     <= '0;
      z_j_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lat_q     <= lat_d;
      a_in_q    <= a_in_d;
      a_i_q     <= a_i_d;
      a_j_q     <= a_j_d;
      a_we_q    <= a_we_d;
      b_in_q    <= b_in_d;
      b_i_q     <= b_i_d;
      b_j_q     <= b_j_d;
      b_we_q    <= b_we_d;
      z_i_q     <= z_i_d;
      z_j_q     <= z_j_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign a_in    = a_in_q;
  assign a_i     = a_i_q;
  assign a_j     = a_j_q;
  assign a_we    = a_we_q;
  assign b_in    = b_in_q;
  assign b_i     = b_i_q;
  assign b_j     = b_j_q;
  assign b_we    = b_we_q;
  assign z_i     = z_i_q;
  assign z_j     = z_j_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule
